// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr_if
// Brief    : Arbitration handshake bundle between SoC bus masters and the
//            round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] requests;
    logic [NUM_MASTERS-1:0] grants;
    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   busErrorIn;
    logic                   endTransactionOut;
    logic                   busErrorOut;
    logic                   busActive;
    logic [IDX_W-1:0]       activeMaster;

    // Bus side: masters and slaves driving requests and transaction markers.
    modport master (
        output requests,
        output beginTransactionIn,
        output endTransactionIn,
        output busErrorIn,
        input  grants,
        input  endTransactionOut,
        input  busErrorOut,
        input  busActive,
        input  activeMaster
    );

    // Arbiter side.
    modport slave (
        input  requests,
        input  beginTransactionIn,
        input  endTransactionIn,
        input  busErrorIn,
        output grants,
        output endTransactionOut,
        output busErrorOut,
        output busActive,
        output activeMaster
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Brief    : Round-robin SoC bus arbiter with begin/active watchdogs that
//            retire stalled or hung transactions.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int BEGIN_TIMEOUT  = 16,
    parameter int ACTIVE_TIMEOUT = 1024
) (
    input  wire logic         clock,
    input  wire logic         reset,
    bus_arbiter_rr_if.slave   bus
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BCNT_W = $clog2(BEGIN_TIMEOUT + 1);
    localparam int ACNT_W = $clog2(ACTIVE_TIMEOUT + 1);

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BEGIN_TIMEOUT - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(BEGIN_TIMEOUT);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ACTIVE_TIMEOUT - 1);
    localparam logic [ACNT_W-1:0] ACNT_MAX  = ACNT_W'(ACTIVE_TIMEOUT);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_WAIT_BEGIN = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_FORCE_END  = 3'd4
    } state_t;

    state_t                 state_q,      state_d;
    logic [IDX_W-1:0]       rr_ptr_q,     rr_ptr_d;
    logic [BCNT_W-1:0]      begin_cnt_q,  begin_cnt_d;
    logic [ACNT_W-1:0]      active_cnt_q, active_cnt_d;
    logic [NUM_MASTERS-1:0] grants_q,     grants_d;
    logic                   end_out_q,    end_out_d;
    logic                   err_out_q,    err_out_d;
    logic                   busy_q,       busy_d;
    logic [IDX_W-1:0]       master_q,     master_d;

    logic [NUM_MASTERS-1:0] req_rot;
    logic                   req_found;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       ptr_next;
    int                     pick_off;
    int                     pick_sum;

    // Rotate requests so the rr pointer lands on bit 0; the lowest set bit
    // of the rotated vector is then the round-robin winner.
    always_comb begin
        req_rot = (bus.requests >> rr_ptr_q)
                | (bus.requests << (NUM_MASTERS - int'(rr_ptr_q)));
        pick_off  = 0;
        req_found = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (((req_rot >> k) & NUM_MASTERS'(1)) != '0) begin
                pick_off  = k;
                req_found = 1'b1;
            end
        end
        pick_sum = int'(rr_ptr_q) + pick_off;
        if (pick_sum >= NUM_MASTERS) begin
            pick_sum = pick_sum - NUM_MASTERS;
        end
        winner   = IDX_W'(pick_sum);
        ptr_next = (winner == IDX_LAST) ? '0 : winner + IDX_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        begin_cnt_d  = begin_cnt_q;
        active_cnt_d = active_cnt_q;
        master_d     = master_q;
        grants_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    state_d  = ST_GRANT;
                    rr_ptr_d = ptr_next;
                    master_d = winner;
                    grants_d = NUM_MASTERS'(1) << winner;
                end
            end

            ST_GRANT: begin
                state_d     = ST_WAIT_BEGIN;
                begin_cnt_d = '0;
            end

            // A granted master that never starts simply forfeits its slot;
            // the pointer has already moved past it.
            ST_WAIT_BEGIN: begin
                if (bus.beginTransactionIn) begin
                    state_d      = ST_ACTIVE;
                    active_cnt_d = '0;
                end else if (begin_cnt_q >= BCNT_LAST) begin
                    state_d = ST_IDLE;
                end else if (begin_cnt_q != BCNT_MAX) begin
                    begin_cnt_d = begin_cnt_q + BCNT_W'(1);
                end
            end

            // A genuine end/error takes precedence over the watchdog firing
            // in the same cycle.
            ST_ACTIVE: begin
                if (bus.endTransactionIn || bus.busErrorIn) begin
                    state_d = ST_IDLE;
                end else if (active_cnt_q >= ACNT_LAST) begin
                    state_d = ST_FORCE_END;
                end else if (active_cnt_q != ACNT_MAX) begin
                    active_cnt_d = active_cnt_q + ACNT_W'(1);
                end
            end

            ST_FORCE_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        end_out_d = (state_d == ST_FORCE_END);
        err_out_d = (state_d == ST_FORCE_END);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            begin_cnt_q  <= '0;
            active_cnt_q <= '0;
            grants_q     <= '0;
            end_out_q    <= 1'b0;
            err_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            master_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            begin_cnt_q  <= begin_cnt_d;
            active_cnt_q <= active_cnt_d;
            grants_q     <= grants_d;
            end_out_q    <= end_out_d;
            err_out_q    <= err_out_d;
            busy_q       <= busy_d;
            master_q     <= master_d;
        end
    end

    assign bus.grants            = grants_q;
    assign bus.endTransactionOut = end_out_q;
    assign bus.busErrorOut       = err_out_q;
    assign bus.busActive         = busy_q;
    assign bus.activeMaster      = master_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Brief    : Self-checking bench for bus_arbiter_rr against a round-robin
//            reference model and timing rules derived from arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

    localparam int N    = 4;
    localparam int BT   = 16;
    localparam int AT   = 64;
    localparam int AM_W = $clog2(N);

    logic clock = 1'b0;
    logic reset;

    bus_arbiter_rr_if #(.NUM_MASTERS(N)) bus ();

    bus_arbiter_rr #(
        .NUM_MASTERS   (N),
        .BEGIN_TIMEOUT (BT),
        .ACTIVE_TIMEOUT(AT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int mptr     = 0;

    int              waited, idle_seen, n_run, f_at, f_cnt, f_mm, exp_w;
    logic [N-1:0]    g;
    logic [AM_W-1:0] am;

    // Reference: first requesting master at or after ptr, modulo N.
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        int pick;
        pick = -1;
        for (int k = N - 1; k >= 0; k--) begin
            int m;
            m = (ptr + k) % N;
            if (((req >> m) & N'(1)) != '0) pick = m;
        end
        return pick;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_pulses();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.requests = '0;
        clear_pulses();
        repeat (2) tick();
        reset = 1'b1;
        mptr  = 0;
        tick();
    endtask

    task automatic wait_grant(input int max_ticks, output int w, output int idl,
                              output logic [N-1:0] gv, output logic [AM_W-1:0] av);
        w = 0; idl = 0; gv = '0; av = '0;
        while (w < max_ticks) begin
            tick();
            w++;
            clear_pulses();
            if (bus.grants != '0) begin
                gv = bus.grants;
                av = bus.activeMaster;
                break;
            end
            if (!bus.busActive) idl++;
        end
    endtask

    task automatic run_until_idle(input int max_ticks, output int n, output int fa,
                                  output int fc, output int mm);
        n = 0; fa = -1; fc = 0; mm = 0;
        while (n < max_ticks) begin
            tick();
            n++;
            clear_pulses();
            if (bus.endTransactionOut) begin
                fc++;
                if (fa < 0) fa = n;
            end
            if (bus.endTransactionOut !== bus.busErrorOut) mm++;
            if (!bus.busActive) break;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.grants !== '0) $display("FAIL reset_grants: got %b want 0", bus.grants);
        else n_pass++;
        n_checks++;
        if (bus.busActive !== 1'b0) $display("FAIL reset_busActive: got %b want 0", bus.busActive);
        else n_pass++;
        n_checks++;
        if (bus.endTransactionOut !== 1'b0 || bus.busErrorOut !== 1'b0)
            $display("FAIL reset_forced: got end=%b err=%b want 0/0", bus.endTransactionOut, bus.busErrorOut);
        else n_pass++;
        n_checks++;
        if (bus.activeMaster !== '0) $display("FAIL reset_activeMaster: got %0d want 0", bus.activeMaster);
        else n_pass++;
    endtask

    task automatic test_single_grant();
        bus.requests = 4'b0100;
        exp_w = model_pick(bus.requests, mptr);
        tick();
        n_checks++;
        if (bus.grants !== (N'(1) << exp_w)) $display("FAIL single_grant: got %b want %b", bus.grants, N'(1) << exp_w);
        else n_pass++;
        n_checks++;
        if (bus.activeMaster !== AM_W'(exp_w)) $display("FAIL single_master: got %0d want %0d", bus.activeMaster, exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        bus.requests = '0;
        tick();
        n_checks++;
        if (bus.grants !== '0) $display("FAIL single_pulse_width: got %b want 0", bus.grants);
        else n_pass++;
        repeat (2) tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (bus.busActive !== 1'b1) $display("FAIL single_active_hold: got %b want 1", bus.busActive);
        else n_pass++;
        bus.endTransactionIn = 1'b1;
        tick();
        bus.endTransactionIn = 1'b0;
        n_checks++;
        if (bus.busActive !== 1'b0 || bus.endTransactionOut !== 1'b0)
            $display("FAIL single_release: got busy=%b end=%b want 0/0", bus.busActive, bus.endTransactionOut);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.requests = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_w = model_pick(bus.requests, mptr);
            wait_grant(6, waited, idle_seen, g, am);
            n_checks++;
            if (g !== (N'(1) << exp_w) || am !== AM_W'(exp_w))
                $display("FAIL b2b_order[%0d]: got %b/%0d want %b/%0d", t, g, am, N'(1) << exp_w, exp_w);
            else n_pass++;
            n_checks++;
            if (waited !== ((t == 0) ? 1 : 2) || idle_seen !== ((t == 0) ? 0 : 1))
                $display("FAIL b2b_gap[%0d]: got wait=%0d idle=%0d want %0d/%0d",
                         t, waited, idle_seen, (t == 0) ? 1 : 2, (t == 0) ? 0 : 1);
            else n_pass++;
            mptr = (exp_w + 1) % N;
            tick();
            bus.beginTransactionIn = 1'b1;
            tick();
            bus.beginTransactionIn = 1'b0;
            bus.endTransactionIn   = 1'b1;
        end
        bus.requests = '0;
        run_until_idle(4, n_run, f_at, f_cnt, f_mm);
    endtask

    task automatic test_begin_timeout();
        bus.requests = 4'b0011;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        n_checks++;
        if (g !== (N'(1) << exp_w)) $display("FAIL bto_first_grant: got %b want %b", g, N'(1) << exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        run_until_idle(BT + 10, n_run, f_at, f_cnt, f_mm);
        n_checks++;
        if (n_run !== BT + 1) $display("FAIL bto_duration: got %0d want %0d", n_run, BT + 1);
        else n_pass++;
        n_checks++;
        if (f_cnt !== 0 || f_mm !== 0) $display("FAIL bto_silent: got forced=%0d mism=%0d want 0/0", f_cnt, f_mm);
        else n_pass++;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        n_checks++;
        if (g !== (N'(1) << exp_w) || waited !== 1)
            $display("FAIL bto_wrap_grant: got %b after %0d want %b after 1", g, waited, N'(1) << exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        bus.requests = '0;
        repeat (BT) tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        n_checks++;
        if (bus.busActive !== 1'b1) $display("FAIL bto_last_cycle_begin: got busy=%b want 1", bus.busActive);
        else n_pass++;
        bus.endTransactionIn = 1'b1;
        run_until_idle(4, n_run, f_at, f_cnt, f_mm);
    endtask

    task automatic test_active_timeout();
        bus.requests = 4'b1000;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        n_checks++;
        if (g !== (N'(1) << exp_w)) $display("FAIL ato_grant: got %b want %b", g, N'(1) << exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        bus.requests = '0;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        run_until_idle(AT + 10, n_run, f_at, f_cnt, f_mm);
        n_checks++;
        if (f_at !== AT || f_cnt !== 1) $display("FAIL ato_pulse: got at=%0d count=%0d want %0d/1", f_at, f_cnt, AT);
        else n_pass++;
        n_checks++;
        if (f_mm !== 0) $display("FAIL ato_err_pair: got %0d cycles end!=err want 0", f_mm);
        else n_pass++;
        n_checks++;
        if (n_run !== AT + 1) $display("FAIL ato_return_idle: got %0d want %0d", n_run, AT + 1);
        else n_pass++;
    endtask

    task automatic test_bus_error();
        bus.requests = 4'b0010;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        mptr = (exp_w + 1) % N;
        bus.requests = '0;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.busErrorIn = 1'b1;
        tick();
        bus.busErrorIn = 1'b0;
        n_checks++;
        if (bus.busActive !== 1'b0 || bus.endTransactionOut !== 1'b0 || bus.busErrorOut !== 1'b0)
            $display("FAIL err_to_idle: got busy=%b end=%b err=%b want 0/0/0",
                     bus.busActive, bus.endTransactionOut, bus.busErrorOut);
        else n_pass++;

        bus.requests = 4'b0001;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        n_checks++;
        if (g !== (N'(1) << exp_w)) $display("FAIL race_grant: got %b want %b", g, N'(1) << exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        bus.requests = '0;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        repeat (AT - 1) tick();
        n_checks++;
        if (bus.busActive !== 1'b1 || bus.endTransactionOut !== 1'b0)
            $display("FAIL race_pre_timeout: got busy=%b end=%b want 1/0", bus.busActive, bus.endTransactionOut);
        else n_pass++;
        bus.endTransactionIn = 1'b1;
        run_until_idle(4, n_run, f_at, f_cnt, f_mm);
        n_checks++;
        if (n_run !== 1 || f_cnt !== 0 || f_mm !== 0)
            $display("FAIL race_end_wins: got n=%0d forced=%0d want 1/0", n_run, f_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.requests = 4'b0100;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        bus.requests = '0;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busActive !== 1'b0 || bus.grants !== '0 || bus.activeMaster !== '0 ||
            bus.endTransactionOut !== 1'b0 || bus.busErrorOut !== 1'b0)
            $display("FAIL async_reset: got busy=%b grants=%b am=%0d end=%b err=%b want all 0",
                     bus.busActive, bus.grants, bus.activeMaster, bus.endTransactionOut, bus.busErrorOut);
        else n_pass++;
        tick();
        reset = 1'b1;
        mptr  = 0;
        bus.requests = 4'b1001;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(4, waited, idle_seen, g, am);
        n_checks++;
        if (g !== (N'(1) << exp_w)) $display("FAIL post_reset_first: got %b want %b", g, N'(1) << exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b1;
        exp_w = model_pick(bus.requests, mptr);
        wait_grant(6, waited, idle_seen, g, am);
        n_checks++;
        if (g !== (N'(1) << exp_w) || am !== AM_W'(exp_w))
            $display("FAIL post_reset_second: got %b/%0d want %b/%0d", g, am, N'(1) << exp_w, exp_w);
        else n_pass++;
        mptr = (exp_w + 1) % N;
        bus.requests = '0;
        tick();
        bus.beginTransactionIn = 1'b1;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b1;
        run_until_idle(4, n_run, f_at, f_cnt, f_mm);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int k, mode, len;
            bus.requests = N'($urandom_range(1, (1 << N) - 1));
            exp_w = model_pick(bus.requests, mptr);
            wait_grant(4, waited, idle_seen, g, am);
            n_checks++;
            if (g !== (N'(1) << exp_w) || am !== AM_W'(exp_w) || waited !== 1)
                $display("FAIL rnd_grant[%0d]: got %b/%0d after %0d want %b/%0d after 1",
                         it, g, am, waited, N'(1) << exp_w, exp_w);
            else n_pass++;
            mptr = (exp_w + 1) % N;
            bus.requests = '0;
            k = $urandom_range(1, BT + 4);
            if (k <= BT) begin
                repeat (k) tick();
                bus.beginTransactionIn = 1'b1;
                tick();
                bus.beginTransactionIn = 1'b0;
                mode = $urandom_range(0, 2);
                if (mode < 2) begin
                    len = ($urandom_range(0, 3) == 0) ? AT : $urandom_range(1, AT);
                    repeat (len - 1) tick();
                    if (mode == 0) bus.endTransactionIn = 1'b1;
                    else           bus.busErrorIn       = 1'b1;
                    run_until_idle(4, n_run, f_at, f_cnt, f_mm);
                    n_checks++;
                    if (n_run !== 1 || f_cnt !== 0 || f_mm !== 0)
                        $display("FAIL rnd_end[%0d]: got n=%0d forced=%0d len=%0d want 1/0", it, n_run, f_cnt, len);
                    else n_pass++;
                end else begin
                    run_until_idle(AT + 10, n_run, f_at, f_cnt, f_mm);
                    n_checks++;
                    if (f_at !== AT || f_cnt !== 1 || f_mm !== 0 || n_run !== AT + 1)
                        $display("FAIL rnd_force[%0d]: got at=%0d cnt=%0d n=%0d want %0d/1/%0d",
                                 it, f_at, f_cnt, n_run, AT, AT + 1);
                    else n_pass++;
                end
            end else begin
                run_until_idle(BT + 10, n_run, f_at, f_cnt, f_mm);
                n_checks++;
                if (n_run !== BT + 1 || f_cnt !== 0 || f_mm !== 0)
                    $display("FAIL rnd_begin_timeout[%0d]: got n=%0d forced=%0d want %0d/0", it, n_run, f_cnt, BT + 1);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.requests = '0;
        clear_pulses();
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        mptr  = 0;
        test_single_grant();
        test_back_to_back();
        test_begin_timeout();
        test_active_timeout();
        test_bus_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
